result_bus_arbiter: RTL

- Shares the result broadcast buses among all reservation stations (integer units and others).
- Each cycle it picks up to BUS_COUNT stations that have a ready result, in round-robin order.
- It drives each winner's index and result onto the bus arrays that the stations snoop, and pulses reset_occupied to the winners so they free themselves.
- It sits between the station array and the flat bus_asserted/bus_source/bus_value arrays.

---
 rtl/result_bus_arbiter_if.sv | 32 +++
 rtl/result_bus_arbiter.sv | 112 +++++++++++
 2 files changed

// File: rtl/result_bus_arbiter_if.sv
// Station-side result handshake plus the flat broadcast bus arrays that every station snoops.
interface result_bus_arbiter_if #(
    parameter int SIZE               = 32,
    parameter int STATION_COUNT      = 4,
    parameter int STATION_INDEX_SIZE = 2,
    parameter int BUS_COUNT          = 1
);
    logic [STATION_COUNT-1:0]                station_result_ready;
    logic [SIZE*STATION_COUNT-1:0]           station_result;
    logic [STATION_COUNT-1:0]                station_reset_occupied;
    logic [BUS_COUNT-1:0]                    bus_asserted;
    logic [STATION_INDEX_SIZE*BUS_COUNT-1:0] bus_source;
    logic [SIZE*BUS_COUNT-1:0]               bus_value;

    modport master (
        input  station_result_ready,
        input  station_result,
        output station_reset_occupied,
        output bus_asserted,
        output bus_source,
        output bus_value
    );

    modport slave (
        output station_result_ready,
        output station_result,
        input  station_reset_occupied,
        input  bus_asserted,
        input  bus_source,
        input  bus_value
    );
endinterface

// File: rtl/result_bus_arbiter.sv
// Round-robin arbiter granting up to BUS_COUNT ready reservation stations per cycle onto the
// result broadcast buses, with a registered free pulse back to each winner.
module result_bus_arbiter #(
    parameter int SIZE               = 32,
    parameter int STATION_COUNT      = 4,
    parameter int STATION_INDEX_SIZE = 2,
    parameter int BUS_COUNT          = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    result_bus_arbiter_if.master rb
);
    localparam int               PTR_W        = (STATION_COUNT > 1) ? $clog2(STATION_COUNT) : 1;
    localparam logic [PTR_W-1:0] LAST_STATION = PTR_W'(STATION_COUNT - 1);
    localparam logic [PTR_W-1:0] ONE          = PTR_W'(1);

    logic [PTR_W-1:0]                        ptr_q, ptr_d;
    logic [BUS_COUNT-1:0]                    bus_asserted_q, bus_asserted_d;
    logic [STATION_INDEX_SIZE*BUS_COUNT-1:0] bus_source_q, bus_source_d;
    logic [SIZE*BUS_COUNT-1:0]               bus_value_q, bus_value_d;
    logic [STATION_COUNT-1:0]                reset_occupied_q, reset_occupied_d;

    logic [SIZE-1:0]          result_arr [STATION_COUNT];
    logic [STATION_COUNT-1:0] eligible;
    logic [STATION_COUNT-1:0] avail;
    logic [PTR_W-1:0]         scan;
    logic [PTR_W-1:0]         sel;
    logic [PTR_W-1:0]         last_sel;
    logic                     found;
    logic                     any_grant;

    always_comb begin
        for (int s = 0; s < STATION_COUNT; s++) begin
            result_arr[s] = rb.station_result[s*SIZE +: SIZE];
        end
    end

    // A station whose free pulse is on the wire still reports ready; masking it avoids a re-grant.
    assign eligible = rb.station_result_ready & ~reset_occupied_q;

    always_comb begin
        bus_asserted_d   = '0;
        bus_source_d     = '0;
        bus_value_d      = '0;
        reset_occupied_d = '0;
        ptr_d            = ptr_q;
        avail            = eligible;
        scan             = ptr_q;
        sel              = '0;
        last_sel         = '0;
        found            = 1'b0;
        any_grant        = 1'b0;

        // Each bus claims the first still-available station scanning round-robin from ptr.
        for (int b = 0; b < BUS_COUNT; b++) begin
            found = 1'b0;
            sel   = '0;
            scan  = ptr_q;
            for (int i = 0; i < STATION_COUNT; i++) begin
                if (!found && avail[scan]) begin
                    found = 1'b1;
                    sel   = scan;
                end
                scan = (scan == LAST_STATION) ? '0 : scan + ONE;
            end
            if (found) begin
                avail[sel]                                              = 1'b0;
                bus_asserted_d[b]                                       = 1'b1;
                bus_source_d[b*STATION_INDEX_SIZE +: STATION_INDEX_SIZE] = STATION_INDEX_SIZE'(sel);
                bus_value_d[b*SIZE +: SIZE]                             = result_arr[sel];
                reset_occupied_d[sel]                                   = 1'b1;
                last_sel                                                = sel;
                any_grant                                               = 1'b1;
            end
        end

        if (any_grant) begin
            ptr_d = (last_sel == LAST_STATION) ? '0 : last_sel + ONE;
        end

        if (flush) begin
            bus_asserted_d   = '0;
            bus_source_d     = '0;
            bus_value_d      = '0;
            reset_occupied_d = '0;
            ptr_d            = ptr_q;
        end
    end

    // Grant register stage: the bus and the free pulse appear together one cycle after ready.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q            <= '0;
            bus_asserted_q   <= '0;
            bus_source_q     <= '0;
            bus_value_q      <= '0;
            reset_occupied_q <= '0;
        end else begin
            ptr_q            <= ptr_d;
            bus_asserted_q   <= bus_asserted_d;
            bus_source_q     <= bus_source_d;
            bus_value_q      <= bus_value_d;
            reset_occupied_q <= reset_occupied_d;
        end
    end

    assign rb.bus_asserted           = bus_asserted_q;
    assign rb.bus_source             = bus_source_q;
    assign rb.bus_value              = bus_value_q;
    assign rb.station_reset_occupied = reset_occupied_q;
endmodule
